// File: rtl/mem_port_perf_monitor_if.sv
// Snoop/readout bundle for the memory-port performance monitor.
// Master drives the control and readout request; slave is the monitor.
interface mem_port_perf_monitor_if #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 32,
  parameter int RD_CH_W = 1
);
  logic              enable;
  logic              clear;
  logic [NUM_CH-1:0] ch_read;
  logic [NUM_CH-1:0] ch_write;
  logic [NUM_CH-1:0] ch_resp;
  logic              rd_en;
  logic [RD_CH_W-1:0] rd_ch;
  logic [2:0]        rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] timeout_flag;

  modport master (
    output enable, clear, ch_read, ch_write, ch_resp, rd_en, rd_ch, rd_sel,
    input  rd_valid, rd_data, timeout_flag
  );

  modport slave (
    input  enable, clear, ch_read, ch_write, ch_resp, rd_en, rd_ch, rd_sel,
    output rd_valid, rd_data, timeout_flag
  );
endinterface

// File: rtl/mem_port_perf_monitor.sv
// Per-channel dfp transaction tracker with saturating event, latency and
// timeout counters, plus a registered readout port.
module mem_port_perf_monitor #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 32,
  parameter int LAT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input logic                     clk,
  input logic                     rst,
  mem_port_perf_monitor_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [LAT_W-1:0] TMO_LAT = LAT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  state_e           state_q   [NUM_CH];
  state_e           state_d   [NUM_CH];
  logic [LAT_W-1:0] lat_q     [NUM_CH];
  logic [LAT_W-1:0] lat_d     [NUM_CH];
  logic [CNT_W-1:0] reads_q   [NUM_CH];
  logic [CNT_W-1:0] reads_d   [NUM_CH];
  logic [CNT_W-1:0] writes_q  [NUM_CH];
  logic [CNT_W-1:0] writes_d  [NUM_CH];
  logic [CNT_W-1:0] lat_sum_q [NUM_CH];
  logic [CNT_W-1:0] lat_sum_d [NUM_CH];
  logic [LAT_W-1:0] lat_max_q [NUM_CH];
  logic [LAT_W-1:0] lat_max_d [NUM_CH];
  logic [CNT_W-1:0] spur_q    [NUM_CH];
  logic [CNT_W-1:0] spur_d    [NUM_CH];
  logic [CNT_W-1:0] tmo_q     [NUM_CH];
  logic [CNT_W-1:0] tmo_d     [NUM_CH];
  logic [NUM_CH-1:0] tflag_q, tflag_d;
  logic [CNT_W-1:0] en_cyc_q, en_cyc_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Adds a latency to a sum, clamping at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [LAT_W-1:0] b);
    logic [CNT_W+LAT_W:0] s;
    s = {{(LAT_W+1){1'b0}}, a} + {{(CNT_W+1){1'b0}}, b};
    if (s > {{(LAT_W+1){1'b0}}, {CNT_W{1'b1}}}) return '1;
    return s[CNT_W-1:0];
  endfunction

  // Presents a latency on the counter-wide readout, clamping if it does not fit.
  function automatic logic [CNT_W-1:0] fit_lat(input logic [LAT_W-1:0] v);
    logic [CNT_W+LAT_W-1:0] w;
    w = {{CNT_W{1'b0}}, v};
    if (w > {{LAT_W{1'b0}}, {CNT_W{1'b1}}}) return '1;
    return w[CNT_W-1:0];
  endfunction

  // Per-channel FSM, latency tracking and counter next-state.
  always_comb begin
    logic             req;
    logic             start;
    logic             done;
    logic             spur_evt;
    logic             tmo_evt;
    logic [LAT_W-1:0] done_lat;
    req      = 1'b0;
    start    = 1'b0;
    done     = 1'b0;
    spur_evt = 1'b0;
    tmo_evt  = 1'b0;
    done_lat = '0;
    tflag_d  = tflag_q;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]   = state_q[c];
      lat_d[c]     = lat_q[c];
      reads_d[c]   = reads_q[c];
      writes_d[c]  = writes_q[c];
      lat_sum_d[c] = lat_sum_q[c];
      lat_max_d[c] = lat_max_q[c];
      spur_d[c]    = spur_q[c];
      tmo_d[c]     = tmo_q[c];
      req      = bus.ch_read[c] | bus.ch_write[c];
      start    = 1'b0;
      done     = 1'b0;
      spur_evt = 1'b0;
      done_lat = '0;
      if (state_q[c] == IDLE) begin
        if (req) begin
          start = 1'b1;
          if (bus.ch_resp[c]) begin
            done = 1'b1;
          end else begin
            state_d[c] = BUSY;
            lat_d[c]   = LAT_ONE;
          end
        end else if (bus.ch_resp[c]) begin
          spur_evt = 1'b1;
        end
      end else begin
        if (bus.ch_resp[c]) begin
          state_d[c] = IDLE;
          done       = 1'b1;
          done_lat   = lat_q[c];
        end else begin
          lat_d[c] = (&lat_q[c]) ? lat_q[c] : lat_q[c] + LAT_ONE;
        end
      end
      // Fires only on the edge where lat first becomes TIMEOUT.
      tmo_evt = (state_d[c] == BUSY) && (lat_d[c] == TMO_LAT) &&
                !((state_q[c] == BUSY) && (lat_q[c] == TMO_LAT));
      if (bus.clear) begin
        reads_d[c]   = '0;
        writes_d[c]  = '0;
        lat_sum_d[c] = '0;
        lat_max_d[c] = '0;
        spur_d[c]    = '0;
        tmo_d[c]     = '0;
        tflag_d[c]   = 1'b0;
      end else begin
        if (tmo_evt) tflag_d[c] = 1'b1;
        if (bus.enable) begin
          if (start && !bus.ch_write[c]) reads_d[c]  = sat_inc(reads_q[c]);
          if (start && bus.ch_write[c])  writes_d[c] = sat_inc(writes_q[c]);
          if (done) begin
            lat_sum_d[c] = sat_add(lat_sum_q[c], done_lat);
            if (done_lat > lat_max_q[c]) lat_max_d[c] = done_lat;
          end
          if (spur_evt) spur_d[c] = sat_inc(spur_q[c]);
          if (tmo_evt)  tmo_d[c]  = sat_inc(tmo_q[c]);
        end
      end
    end
  end

  // Global enabled-cycle counter next-state.
  always_comb begin
    en_cyc_d = en_cyc_q;
    if (bus.clear)       en_cyc_d = '0;
    else if (bus.enable) en_cyc_d = sat_inc(en_cyc_q);
  end

  // Readout mux over the pre-update counter values; data holds when idle.
  always_comb begin
    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    if (bus.rd_en) begin
      rd_data_d = '0;
      if (bus.rd_sel == 3'd7) begin
        rd_data_d = en_cyc_q;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (int'(bus.rd_ch) == c) begin
            case (bus.rd_sel)
              3'd0:    rd_data_d = reads_q[c];
              3'd1:    rd_data_d = writes_q[c];
              3'd2:    rd_data_d = lat_sum_q[c];
              3'd3:    rd_data_d = fit_lat(lat_max_q[c]);
              3'd4:    rd_data_d = spur_q[c];
              3'd5:    rd_data_d = tmo_q[c];
              3'd6:    rd_data_d = CNT_W'(state_q[c] == BUSY);
              default: rd_data_d = '0;
            endcase
          end
        end
      end
    end
  end

  // State, counter and readout registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]   <= IDLE;
        lat_q[c]     <= '0;
        reads_q[c]   <= '0;
        writes_q[c]  <= '0;
        lat_sum_q[c] <= '0;
        lat_max_q[c] <= '0;
        spur_q[c]    <= '0;
        tmo_q[c]     <= '0;
      end
      tflag_q    <= '0;
      en_cyc_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]   <= state_d[c];
        lat_q[c]     <= lat_d[c];
        reads_q[c]   <= reads_d[c];
        writes_q[c]  <= writes_d[c];
        lat_sum_q[c] <= lat_sum_d[c];
        lat_max_q[c] <= lat_max_d[c];
        spur_q[c]    <= spur_d[c];
        tmo_q[c]     <= tmo_d[c];
      end
      tflag_q    <= tflag_d;
      en_cyc_q   <= en_cyc_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.timeout_flag = tflag_q;

endmodule

// File: tb/tb_mem_port_perf_monitor.sv
// Directed bench: a 3-channel 32-bit monitor (TIMEOUT=8) and a 1-channel
// 4-bit monitor for saturation and enable gating.
module tb_mem_port_perf_monitor;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_port_perf_monitor_if #(.NUM_CH(3), .CNT_W(32), .RD_CH_W(2)) ifa ();
  mem_port_perf_monitor_if #(.NUM_CH(1), .CNT_W(4),  .RD_CH_W(1)) ifs ();

  mem_port_perf_monitor #(.NUM_CH(3), .CNT_W(32), .LAT_W(16), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  mem_port_perf_monitor #(.NUM_CH(1), .CNT_W(4), .LAT_W(8), .TIMEOUT(100)) dut_s (
    .clk(clk), .rst(rst), .bus(ifs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input bit s, input int ch, input bit wr, input logic v);
    if (!s) begin
      if (wr) ifa.ch_write[ch] = v; else ifa.ch_read[ch] = v;
    end else begin
      if (wr) ifs.ch_write[ch] = v; else ifs.ch_read[ch] = v;
    end
  endtask

  task automatic set_resp(input bit s, input int ch, input logic v);
    if (!s) ifa.ch_resp[ch] = v; else ifs.ch_resp[ch] = v;
  endtask

  // Request held from the start edge; resp sampled lat edges later (0 = same edge).
  task automatic do_txn(input bit s, input int ch, input bit wr, input int lat, input bit drop);
    set_req(s, ch, wr, 1'b1);
    if (lat > 0) begin
      tick();
      repeat (lat - 1) tick();
    end
    set_resp(s, ch, 1'b1);
    tick();
    set_resp(s, ch, 1'b0);
    if (drop) set_req(s, ch, wr, 1'b0);
  endtask

  task automatic rd(input bit s, input int ch, input int sel, input int exp,
                    input string tag, input bit clr = 1'b0);
    logic [31:0] d;
    logic        v;
    if (!s) begin
      ifa.rd_en = 1'b1; ifa.rd_ch = 2'(ch); ifa.rd_sel = 3'(sel); ifa.clear = clr;
    end else begin
      ifs.rd_en = 1'b1; ifs.rd_ch = 1'(ch); ifs.rd_sel = 3'(sel);
    end
    tick();
    if (!s) begin
      d = ifa.rd_data; v = ifa.rd_valid; ifa.rd_en = 1'b0; ifa.clear = 1'b0;
    end else begin
      d = 32'(ifs.rd_data); v = ifs.rd_valid; ifs.rd_en = 1'b0;
    end
    check({tag, "_vld"}, 32'(v), 32'd1);
    check(tag, d, 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifa.enable = 1'b1; ifa.clear = 1'b0; ifa.ch_read = '0; ifa.ch_write = '0;
    ifa.ch_resp = '0; ifa.rd_en = 1'b1; ifa.rd_ch = '0; ifa.rd_sel = 3'd7;
    ifs.enable = 1'b1; ifs.clear = 1'b0; ifs.ch_read = '0; ifs.ch_write = '0;
    ifs.ch_resp = '0; ifs.rd_en = 1'b0; ifs.rd_ch = '0; ifs.rd_sel = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_vld", 32'(ifa.rd_valid), 32'd0);
    check("rst_data", ifa.rd_data, 32'd0);
    check("rst_flag", 32'(ifa.timeout_flag), 32'd0);
    ifa.rd_en = 1'b0;
    rst = 1'b0;
    rd(0, 0, 0, 0, "rst_reads");

    // Single read on ch0, latency 5
    do_txn(0, 0, 0, 5, 1);
    rd(0, 0, 0, 1, "t1_reads");
    rd(0, 0, 2, 5, "t1_lat_sum");
    tick();
    check("t1_idle_vld", 32'(ifa.rd_valid), 32'd0);
    check("t1_hold_data", ifa.rd_data, 32'd5);
    rd(0, 0, 3, 5, "t1_lat_max");
    rd(0, 0, 6, 0, "t1_busy");

    // Back-to-back writes on ch1, latencies 3 then 7
    do_txn(0, 1, 1, 3, 0);
    do_txn(0, 1, 1, 7, 1);
    rd(0, 1, 1, 2, "t2_writes");
    rd(0, 1, 0, 0, "t2_reads");
    rd(0, 1, 2, 10, "t2_lat_sum");
    rd(0, 1, 3, 7, "t2_lat_max");

    // Spurious response, then zero-latency read, on ch2
    set_resp(0, 2, 1'b1);
    tick();
    set_resp(0, 2, 1'b0);
    rd(0, 2, 4, 1, "t3_spur");
    rd(0, 2, 0, 0, "t3_reads_none");
    do_txn(0, 2, 0, 0, 1);
    rd(0, 2, 0, 1, "t3_zl_reads");
    rd(0, 2, 2, 0, "t3_zl_lat_sum");
    rd(0, 2, 6, 0, "t3_zl_busy");

    // Timeout on ch0: read outstanding 20 cycles with TIMEOUT=8
    ifa.ch_read[0] = 1'b1;
    tick();
    repeat (9) tick();
    check("t4_flag_busy", 32'(ifa.timeout_flag), 32'd1);
    rd(0, 0, 5, 1, "t4_tmo_busy");
    rd(0, 0, 6, 1, "t4_busy");
    repeat (8) tick();
    ifa.ch_resp[0] = 1'b1;
    tick();
    ifa.ch_resp[0] = 1'b0;
    ifa.ch_read[0] = 1'b0;
    rd(0, 0, 5, 1, "t4_tmo_once");
    rd(0, 0, 2, 25, "t4_lat_sum");
    rd(0, 0, 3, 20, "t4_lat_max");
    rd(0, 0, 0, 2, "t4_reads");
    check("t4_flag", 32'(ifa.timeout_flag), 32'd1);

    // Clear with a same-cycle readout returns the pre-clear value
    rd(0, 0, 2, 25, "clr_pre_value", 1'b1);
    check("clr_flag", 32'(ifa.timeout_flag), 32'd0);
    rd(0, 0, 2, 0, "clr_lat_sum");
    rd(0, 1, 1, 0, "clr_writes");
    rd(0, 0, 3, 0, "clr_lat_max");
    rd(0, 0, 5, 0, "clr_tmo");

    // Saturation with 4-bit counters
    repeat (17) do_txn(1, 0, 0, 0, 1);
    rd(1, 0, 0, 15, "sat_reads");
    rd(1, 0, 7, 15, "sat_en_cyc");
    ifs.clear = 1'b1;
    tick();
    ifs.clear = 1'b0;
    repeat (2) do_txn(1, 0, 0, 0, 1);
    ifs.enable = 1'b0;
    repeat (3) do_txn(1, 0, 0, 0, 1);
    rd(1, 0, 0, 2, "dis_reads");
    rd(1, 0, 7, 2, "dis_en_cyc");
    // Start while disabled, complete while enabled: latency counted, read not
    ifs.ch_read[0] = 1'b1;
    tick();
    ifs.enable = 1'b1;
    tick();
    ifs.ch_resp[0] = 1'b1;
    tick();
    ifs.ch_resp[0] = 1'b0;
    ifs.ch_read[0] = 1'b0;
    rd(1, 0, 0, 2, "mix_reads");
    rd(1, 0, 2, 2, "mix_lat_sum");
    rd(1, 0, 7, 6, "mix_en_cyc");
    do_txn(1, 0, 0, 20, 1);
    rd(1, 0, 2, 15, "sat_lat_sum");
    rd(1, 1, 0, 0, "s_oor");

    // Asynchronous reset in the middle of a ch1 transaction
    ifa.ch_resp[0] = 1'b1;
    tick();
    ifa.ch_resp[0] = 1'b0;
    ifa.ch_read[1] = 1'b1;
    tick();
    repeat (8) tick();
    rd(0, 0, 4, 1, "pre_rst_spur");
    check("pre_rst_flag", 32'(ifa.timeout_flag), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_vld", 32'(ifa.rd_valid), 32'd0);
    check("arst_data", ifa.rd_data, 32'd0);
    check("arst_flag", 32'(ifa.timeout_flag), 32'd0);
    #1 rst = 1'b0;
    ifa.ch_read[1] = 1'b0;
    ifa.ch_resp[1] = 1'b1;
    tick();
    ifa.ch_resp[1] = 1'b0;
    rd(0, 0, 4, 0, "post_rst_spur0");
    rd(0, 1, 0, 0, "post_rst_reads1");
    rd(0, 1, 6, 0, "post_rst_busy1");
    rd(0, 1, 4, 1, "post_rst_spur1");
    rd(0, 3, 4, 0, "oor_ch");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
